// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: oversamples sd_clk, deframes 48-bit host commands
// with CRC7 checking, and serialises the card's 48-bit short response back onto CMD.
`timescale 1ns/1ps
module sd_card_cmd_responder #(
    parameter int NCR         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_clk,
    input  logic        sd_cmd_in,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_err,
    output logic        rsp_ready,
    input  logic        rsp_valid,
    input  logic        rsp_skip,
    input  logic [5:0]  rsp_index,
    input  logic [31:0] rsp_payload,
    output logic        busy
);

    localparam int NW = $clog2(NCR + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_CHECK,
        S_WAIT_RSP,
        S_SEND_WAIT,
        S_SEND
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] cmd_sync;
    logic                   clk_prev;
    logic                   sd_rise;
    logic                   sd_fall;
    logic                   cmd_s;
    logic [46:0]            rx_shift;
    logic [47:0]            tx_shift;
    logic [6:0]             crc;
    logic [5:0]             bit_cnt;
    logic [5:0]             tx_cnt;
    logic [NW-1:0]          ncr_cnt;
    logic                   frame_bad;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_of(input logic [39:0] data);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_next(c, data[i]);
        end
        return c;
    endfunction

    // Both lines share the same synchroniser depth so data stays aligned with the clock edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '0;
            cmd_sync <= '1;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], sd_clk};
            cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], sd_cmd_in};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign sd_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign sd_fall = ~clk_sync[SYNC_STAGES-1] & clk_prev;
    assign cmd_s   = cmd_sync[SYNC_STAGES-1];
    assign busy    = (state != S_IDLE);

    // rx_shift holds everything after the start bit: [46] transmission, [7:1] CRC, [0] end.
    assign frame_bad = (rx_shift[7:1] != crc) | ~rx_shift[46] | ~rx_shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sd_cmd_oe  <= 1'b0;
            sd_cmd_out <= 1'b1;
            cmd_valid  <= 1'b0;
            cmd_index  <= '0;
            cmd_arg    <= '0;
            cmd_err    <= 1'b0;
            rsp_ready  <= 1'b0;
            rx_shift   <= '0;
            tx_shift   <= '1;
            crc        <= '0;
            bit_cnt    <= '0;
            tx_cnt     <= '0;
            ncr_cnt    <= '0;
        end else begin
            cmd_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    sd_cmd_oe  <= 1'b0;
                    sd_cmd_out <= 1'b1;
                    if (sd_rise && !cmd_s) begin
                        rx_shift <= '0;
                        crc      <= '0;
                        bit_cnt  <= 6'd1;
                        state    <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (sd_rise) begin
                        rx_shift <= {rx_shift[45:0], cmd_s};
                        if (bit_cnt < 6'd40) begin
                            crc <= crc7_next(crc, cmd_s);
                        end
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd47) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    cmd_index <= rx_shift[45:40];
                    cmd_arg   <= rx_shift[39:8];
                    cmd_err   <= frame_bad;
                    cmd_valid <= 1'b1;
                    ncr_cnt   <= '0;
                    if (frame_bad) begin
                        state <= S_IDLE;
                    end else begin
                        rsp_ready <= 1'b1;
                        state     <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (sd_rise && ncr_cnt != NW'(NCR)) begin
                        ncr_cnt <= ncr_cnt + 1'b1;
                    end
                    if (rsp_valid) begin
                        rsp_ready <= 1'b0;
                        if (rsp_skip) begin
                            state <= S_IDLE;
                        end else begin
                            tx_shift <= {2'b00, rsp_index, rsp_payload,
                                         crc7_of({2'b00, rsp_index, rsp_payload}), 1'b1};
                            state    <= S_SEND_WAIT;
                        end
                    end
                end
                S_SEND_WAIT: begin
                    if (sd_rise && ncr_cnt != NW'(NCR)) begin
                        ncr_cnt <= ncr_cnt + 1'b1;
                    end
                    // Rise and fall never coincide, so the Ncr count seen here is settled.
                    if (sd_fall && ncr_cnt >= NW'(NCR)) begin
                        sd_cmd_oe  <= 1'b1;
                        sd_cmd_out <= tx_shift[47];
                        tx_shift   <= {tx_shift[46:0], 1'b1};
                        tx_cnt     <= 6'd1;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (sd_fall) begin
                        if (tx_cnt == 6'd48) begin
                            sd_cmd_oe  <= 1'b0;
                            sd_cmd_out <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            sd_cmd_out <= tx_shift[47];
                            tx_shift   <= {tx_shift[46:0], 1'b1};
                            tx_cnt     <= tx_cnt + 6'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sd_card_cmd_responder.md
Name: sd_card_cmd_responder

Overview:
- Card-side endpoint of the SD CMD line, i.e. the other end of the host controller's command path.
- Oversamples `sd_clk` and deframes 48-bit host commands (CRC7 checked), then hands them to card logic.
- Serialises the 48-bit short response that the card logic supplies back onto the open-drain-style CMD line.
- Used as a bench/card model behind the host controller and as the command front end of a future card emulator.

Parameters:
- `NCR`, 2, minimum `sd_clk` rising edges between command end bit and response start bit (legal 2..64).
- `SYNC_STAGES`, 2, flip-flop depth used to synchronise `sd_clk` and `sd_cmd_in` into `clk`.

Ports:
- `clk` input 1: system clock; must be at least 4x `sd_clk`.
- `rst` input 1: synchronous reset, active-high.
- `sd_clk` input 1: SD bus clock from the host.
- `sd_cmd_in` input 1: sampled CMD line.
- `sd_cmd_out` output 1: CMD drive value.
- `sd_cmd_oe` output 1: CMD drive enable; the line is released when 0.
- `cmd_valid` output 1: one-clk pulse, a command frame has completed.
- `cmd_index` output 6: command index of the last frame.
- `cmd_arg` output 32: argument of the last frame.
- `cmd_err` output 1: qualifies `cmd_valid`; indicates a CRC7 mismatch, transmission bit not 1, or end bit not 1.
- `rsp_ready` output 1: responder is waiting for a response decision.
- `rsp_valid` input 1: response decision offered.
- `rsp_skip` input 1: with `rsp_valid`, send no response.
- `rsp_index` input 6: response index field.
- `rsp_payload` input 32: response payload (card status / argument).
- `busy` output 1: state is not IDLE.

Behaviour:
- **Reset values:** `sd_cmd_oe`=0, `sd_cmd_out`=1, `cmd_valid`=0, `cmd_index`=0, `cmd_arg`=0, `cmd_err`=0, `rsp_ready`=0, `busy`=0, state IDLE.
- **Reset mid-operation:** `rst` in any state, including SEND, drops `sd_cmd_oe` on the next `clk` edge.
- **Edge detection:** `sd_clk` and `sd_cmd_in` are synchronised through `SYNC_STAGES` flops.
  - rise = synced high and previous synced low; fall = the opposite.
  - Receive samples on rise; transmit updates `sd_cmd_out` on fall.
- **CRC7:** polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits (start, transmission, index, arg), MSB first.
- **IDLE:**
  - `sd_cmd_oe`=0.
  - A rise with `sd_cmd_in`=0 marks the start bit: bit counter=1, go to RECV.
- **RECV:**
  - Shift one bit per rise, MSB first, until 48 bits are captured.
  - The 48th bit (end bit) moves the state to CHECK.
- **CHECK (1 clk):**
  - Load `cmd_index` and `cmd_arg`; pulse `cmd_valid`.
  - `cmd_err`=1 if the received CRC differs from the computed CRC, the transmission bit is 0, or the end bit is 0.
  - If `cmd_err`, go to IDLE; no response is ever driven.
  - Otherwise go to WAIT_RSP and clear the Ncr counter.
- **WAIT_RSP:**
  - `rsp_ready`=1.
  - The Ncr counter increments on each rise and saturates at `NCR`.
  - `rsp_valid` & `rsp_skip`: go to IDLE.
  - `rsp_valid` & !`rsp_skip`: latch the frame {0, 0, `rsp_index`, `rsp_payload`, CRC7, 1} and go to SEND_WAIT.
  - `rsp_ready` drops the clk after acceptance.
  - `rsp_valid` in any other state is ignored.
- **SEND_WAIT:**
  - Keep counting rises.
  - On the first fall with counter >= `NCR`, set `sd_cmd_oe`=1 and drive the start bit 0, then go to SEND.
  - A late response with the counter already saturated starts on the next fall.
- **SEND:**
  - Each fall drives the next bit, 48 bits total.
  - On the fall after the end bit, set `sd_cmd_oe`=0 and `sd_cmd_out`=1, then go to IDLE.
  - Rises seen on `sd_cmd_in` while driving are ignored.
- **Receive latency:** `cmd_valid` asserts 1 clk after the clk in which the end-bit rise is detected.

Test Plan:
- **CMD0:** send frame 0x40_00000000_95, answer with `rsp_skip` -> one `cmd_valid` with `cmd_index`=0, `cmd_arg`=0x00000000, `cmd_err`=0; `sd_cmd_oe` stays 0 throughout.
- **CMD8 with response:** send CMD8 arg 0x000001AA (frame 0x48_000001AA_87); respond with `rsp_index`=8, `rsp_payload`=0x000001AA -> start bit appears no earlier than the 2nd rise after the end bit; 48 captured bits equal {0x08, 0x000001AA, CRC7 from bench model, 1}; `sd_cmd_oe` falls on the fall after the end bit.
- **Bad CRC:** send CMD17 arg 0 with CRC byte 0x54 instead of 0x55 -> `cmd_valid` with `cmd_err`=1; `rsp_ready` never asserts; line never driven.
- **Bad end bit:** send CMD0 with end bit 0 -> `cmd_err`=1, return to IDLE; a following valid CMD0 decodes cleanly.
- **Late response:** withhold `rsp_valid` for 10 `sd_clk` periods, pulse `rsp_valid` in IDLE beforehand -> the early pulse is ignored; transmission starts on the first fall after acceptance.
- **Reset mid-response:** assert `rst` at bit 20 of SEND -> `sd_cmd_oe`=0 next clk, all outputs at reset values; a subsequent CMD0 decodes correctly.
